// File: rtl/frame_pixel_streamer.sv
// rtl/frame_pixel_streamer.sv - raster-order pixel source from frame RAM; optional INVERT_ON_BEAT_EN
module frame_pixel_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH*IMG_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic                  beat_detected,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  module_ready,
  output logic [DATA_WIDTH-1:0] pixel_out,
  output logic                  pixel_out_valid,
  output logic                  sof,
  output logic                  eol,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int XW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int YW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int EW = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(IMG_WIDTH*IMG_HEIGHT-1);
  localparam logic [XW-1:0]         LAST_X    = XW'(IMG_WIDTH-1);

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DRAIN, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [XW-1:0]           x_q;
  logic [YW-1:0]           y_q;
  logic                    inflight_q;
  logic                    tag_sof_q, tag_eol_q;
  logic [EW-1:0]           head_q, tail_q;
  logic [1:0]              count_q, count_d;
  logic                    pop, push, issue;
  logic [2:0]              occ;
  logic [DATA_WIDTH-1:0]   push_pix;
  logic [EW-1:0]           push_entry;

`ifdef INVERT_ON_BEAT_EN
  logic beat_armed_q;
  logic invert_q;

  // Beat arms inversion for the next frame; the decision is frozen at frame_start
  always_ff @(posedge clk) begin
    if (reset) begin
      beat_armed_q <= 1'b0;
      invert_q     <= 1'b0;
    end else if (state_q == S_IDLE && frame_start) begin
      invert_q     <= beat_armed_q;
      beat_armed_q <= beat_detected;
    end else if (beat_detected && state_q != S_DONE) begin
      beat_armed_q <= 1'b1;
    end
  end

  assign push_pix = invert_q ? ~rd_data : rd_data;
`else
  logic unused_beat;
  assign unused_beat = beat_detected;
  assign push_pix    = rd_data;
`endif

  assign push_entry = {tag_sof_q, tag_eol_q, push_pix};

  // Credit check counts this cycle's pop so a full-rate stream keeps one read in flight
  always_comb begin
    pop     = (count_q != 2'd0) && module_ready;
    push    = inflight_q;
    occ     = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue   = (state_q == S_STREAM) && (occ < 3'd2);
    count_d = count_q + {1'b0, push} - {1'b0, pop};
  end

  // Frame sequencing: stream reads, drain the pipe, then pulse done
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (frame_start) state_d = S_STREAM;
      S_STREAM: if (issue && addr_q == LAST_ADDR) state_d = S_DRAIN;
      S_DRAIN:  if (count_d == 2'd0 && !inflight_q) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Read address and raster position; sof/eol tags travel with the outstanding read
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_sof_q  <= 1'b0;
      tag_eol_q  <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        tag_sof_q <= (x_q == '0) && (y_q == '0);
        tag_eol_q <= (x_q == LAST_X);
      end
      if (state_q == S_IDLE && frame_start) begin
        addr_q <= '0;
        x_q    <= '0;
        y_q    <= '0;
      end else if (issue && addr_q != LAST_ADDR) begin
        addr_q <= addr_q + ADDR_WIDTH'(1);
        if (x_q == LAST_X) begin
          x_q <= '0;
          y_q <= y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
    end
  end

  // Two-entry output FIFO; head register drives the stream outputs directly
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      count_q <= count_d;
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) head_q <= push_entry;
          else                 tail_q <= push_entry;
        end
        2'b01: head_q <= tail_q;
        2'b11: begin
          if (count_q == 2'd1) begin
            head_q <= push_entry;
          end else begin
            head_q <= tail_q;
            tail_q <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_en           = issue;
  assign rd_addr         = addr_q;
  assign pixel_out       = head_q[DATA_WIDTH-1:0];
  assign eol             = head_q[DATA_WIDTH];
  assign sof             = head_q[DATA_WIDTH+1];
  assign pixel_out_valid = (count_q != 2'd0);
  assign busy            = (state_q == S_STREAM) || (state_q == S_DRAIN);
  assign frame_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// tb/tb_frame_pixel_streamer.sv - directed self-checking bench for frame_pixel_streamer (4x2 frame)
module tb_frame_pixel_streamer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_start = 1'b0;
  logic       beat_detected = 1'b0;
  logic       module_ready = 1'b0;
  logic       rd_en;
  logic [2:0] rd_addr;
  logic [7:0] rd_data = 8'd0;
  logic [7:0] pixel_out;
  logic       pixel_out_valid, sof, eol, busy, frame_done;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic [7:0] ram [8];

  int   q_pix[$];
  int   q_sof[$];
  int   q_eol[$];
  int   q_cyc[$];
  int   n_rd, n_xfer, max_out, stall_err, addr_err, done_cnt, done_cyc, first_rd;
  logic       prev_stall;
  logic [7:0] prev_pix;
  logic       prev_sof, prev_eol;

  frame_pixel_streamer #(
    .DATA_WIDTH(8),
    .IMG_WIDTH (4),
    .IMG_HEIGHT(2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .frame_start    (frame_start),
    .beat_detected  (beat_detected),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .rd_data        (rd_data),
    .module_ready   (module_ready),
    .pixel_out      (pixel_out),
    .pixel_out_valid(pixel_out_valid),
    .sof            (sof),
    .eol            (eol),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  initial for (int i = 0; i < 8; i++) ram[i] = 8'(i + 10);

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    q_pix.delete(); q_sof.delete(); q_eol.delete(); q_cyc.delete();
    n_rd = 0; n_xfer = 0; max_out = 0; stall_err = 0; addr_err = 0;
    done_cnt = 0; done_cyc = -1; first_rd = -1; prev_stall = 1'b0;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!pixel_out_valid || pixel_out !== prev_pix ||
                         sof !== prev_sof || eol !== prev_eol))
        stall_err++;
      prev_stall = pixel_out_valid && !module_ready;
      prev_pix = pixel_out; prev_sof = sof; prev_eol = eol;
      if (rd_en) begin
        if (int'(rd_addr) != n_rd || n_rd >= 8) addr_err++;
        if (first_rd < 0) first_rd = cyc;
        n_rd++;
      end
      if (pixel_out_valid && module_ready) begin
        q_pix.push_back(int'(pixel_out));
        q_sof.push_back(int'(sof));
        q_eol.push_back(int'(eol));
        q_cyc.push_back(cyc);
        n_xfer++;
      end
      if (n_rd - n_xfer > max_out) max_out = n_rd - n_xfer;
      if (frame_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  function automatic logic rdy(input int mode, input int i);
    case (mode)
      1:       return (i % 4 == 0) || (i % 4 == 3);
      2:       return i >= 20;
      default: return 1'b1;
    endcase
  endfunction

  task automatic run_frame(input int mode, input int restart_at, input int beat_at, output int t0);
    int post;
    clear_mon();
    @(posedge clk); #1;
    frame_start = 1'b1;
    module_ready = rdy(mode, 0);
    t0 = cyc;
    post = 0;
    for (int i = 1; i < 400; i++) begin
      @(posedge clk); #1;
      frame_start   = (i == restart_at);
      beat_detected = (i == beat_at);
      module_ready  = rdy(mode, i);
      if (i == 1) check("busy_on", busy, 1);
      if (mode == 2 && i == 20) begin
        check("stall_reads", n_rd, 2);
        check("stall_pix", pixel_out, 10);
        check("stall_valid", pixel_out_valid, 1);
        check("stall_xfers", q_pix.size(), 0);
      end
      if (done_cnt > 0) post++;
      if (post >= 6) break;
    end
    frame_start = 1'b0;
    beat_detected = 1'b0;
    check("done_seen", done_cnt > 0, 1);
    check("busy_off", busy, 0);
  endtask

  task automatic check_frame(input bit inv);
    logic [7:0] sm, em;
    int exp;
    sm = '0; em = '0;
    check("n_pix", q_pix.size(), 8);
    for (int k = 0; k < q_pix.size() && k < 8; k++) begin
      exp = inv ? 255 - (10 + k) : 10 + k;
      check("pix", q_pix[k], exp);
      sm[k] = q_sof[k][0];
      em[k] = q_eol[k][0];
    end
    check("sof_mask", sm, 8'h01);
    check("eol_mask", em, 8'h88);
    check("done_cnt", done_cnt, 1);
    check("n_rd", n_rd, 8);
    check("addr_seq", addr_err, 0);
    check("stall_stable", stall_err, 0);
    check("max_outst", max_out, 2);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, n, rd_snap;
    clear_mon();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_valid", pixel_out_valid, 0);
    check("rst_rd_en", rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_pix", pixel_out, 0);

    // full-rate frame with exact latency
    run_frame(0, -1, -1, t0);
    check_frame(0);
    check("first_rd_cyc", first_rd, t0 + 1);
    if (q_cyc.size() == 8) begin
      check("first_pix_cyc", q_cyc[0], t0 + 3);
      check("last_pix_cyc", q_cyc[7], t0 + 10);
    end
    check("done_cyc", done_cyc, t0 + 11);

    // 1,0,0,1 backpressure
    run_frame(1, -1, -1, t0);
    check_frame(0);

    // long initial stall
    run_frame(2, -1, -1, t0);
    check_frame(0);

    // frame_start mid-frame ignored
    run_frame(0, 4, -1, t0);
    check_frame(0);

    // beat mid-frame affects only the following frame
    run_frame(0, -1, 3, t0);
    check_frame(0);
    run_frame(0, -1, -1, t0);
`ifdef INVERT_ON_BEAT_EN
    check_frame(1);
`else
    check_frame(0);
`endif
    run_frame(0, -1, -1, t0);
    check_frame(0);

    // reset after the third transfer aborts the frame
    clear_mon();
    @(posedge clk); #1;
    frame_start = 1'b1;
    module_ready = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    n = 0;
    while (q_pix.size() < 3 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("abort_reach", n < 50, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_valid", pixel_out_valid, 0);
    check("abort_rd_en", rd_en, 0);
    check("abort_pix", pixel_out, 0);
    check("abort_sof", sof, 0);
    check("abort_eol", eol, 0);
    check("abort_busy", busy, 0);
    check("abort_done", frame_done, 0);
    check("abort_xfers", q_pix.size(), 3);
    rd_snap = n_rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("abort_no_rd", n_rd, rd_snap);
    run_frame(0, -1, -1, t0);
    check_frame(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
